// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the CPU memory stage and a
// debug/loader port; each access runs IDLE -> ISSUE -> (WAIT) -> DONE.
module dmem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // The ISSUE cycle is the first latency cycle, so WAIT only covers the rest.
  localparam logic [2:0] LAT_LOAD  = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;
  localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);

  state_t      state, state_nxt;
  logic        own;          // 0 = CPU, 1 = DBG
  logic        we_r;
  logic [2:0]  lat_cnt;
  logic [3:0]  starve_cnt;
  logic        grant_any;
  logic        grant_dbg;
  logic        capture;

  assign grant_any = cpu_req | dbg_req;
  assign grant_dbg = dbg_req & (~cpu_req | (starve_cnt >= STARVE_TH));

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      S_IDLE:  if (grant_any) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (we_r) begin
          state_nxt = S_DONE;
        end else if (MEM_LAT == 1) begin
          state_nxt = S_DONE;
          capture   = 1'b1;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt == 3'd0) begin
          state_nxt = S_DONE;
          capture   = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_en    = (state == S_ISSUE);
  assign mem_we    = mem_en & we_r;
  assign cpu_done  = (state == S_DONE) & ~own;
  assign dbg_ack   = (state == S_DONE) & own;
  assign cpu_stall = cpu_req & ~cpu_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      own        <= 1'b0;
      we_r       <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      lat_cnt    <= 3'd0;
      starve_cnt <= 4'd0;
      cpu_rdata  <= 32'd0;
      dbg_rdata  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && grant_any) begin
        own <= grant_dbg;
        if (grant_dbg) begin
          we_r       <= dbg_we;
          mem_addr   <= dbg_addr;
          mem_wdata  <= dbg_wdata;
          starve_cnt <= 4'd0;
        end else begin
          we_r      <= cpu_we;
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
          if (dbg_req && starve_cnt != 4'd15) starve_cnt <= starve_cnt + 4'd1;
        end
      end
      if (state == S_ISSUE) lat_cnt <= LAT_LOAD;
      else if (state == S_WAIT && lat_cnt != 3'd0) lat_cnt <= lat_cnt - 3'd1;
      if (capture) begin
        if (own) dbg_rdata <= mem_rdata;
        else     cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a 3-cycle-latency memory model and a completion
// scoreboard per port.
module tb_dmem_arbiter;

  localparam int LAT = 3;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_done;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_ack;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] rd_pipe [0:LAT-2];
  logic [32:0] cpu_q[$];
  logic [32:0] dbg_q[$];

  int n, cw, k, cd, da;
  logic pend;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory: read data appears only in the last latency cycle, garbage otherwise.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : BAD;
    for (int i = 1; i < LAT - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (mem_we) chk("we_without_en", {31'd0, mem_en}, 32'd1);
    if (cpu_done) begin
      if (cpu_q.size() == 0) chk("cpu_unexpected_done", 32'd1, 32'd0);
      else begin
        e = cpu_q.pop_front();
        if (e[32]) chk("cpu_rdata", cpu_rdata, e[31:0]);
      end
    end
    if (dbg_ack) begin
      if (dbg_q.size() == 0) chk("dbg_unexpected_ack", 32'd1, 32'd0);
      else begin
        e = dbg_q.pop_front();
        if (e[32]) chk("dbg_rdata", dbg_rdata, e[31:0]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    if (we) begin
      ref_mem[addr[7:0]] = data;
      cpu_q.push_back({1'b0, 32'd0});
    end else cpu_q.push_back({1'b1, ref_mem[addr[7:0]]});
  endtask

  task automatic dbg_drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = data;
    if (we) begin
      ref_mem[addr[7:0]] = data;
      dbg_q.push_back({1'b0, 32'd0});
    end else dbg_q.push_back({1'b1, ref_mem[addr[7:0]]});
  endtask

  task automatic cpu_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input int exp_lat);
    int c;
    cpu_drive(we, addr, data);
    c = 0;
    #3;
    while (!cpu_done && c < 30) begin tick; #3; c++; end
    chk("cpu_latency", 32'(c), 32'(exp_lat));
    tick;
    cpu_req = 1'b0;
  endtask

  task automatic dbg_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input int exp_lat);
    int c;
    dbg_drive(we, addr, data);
    c = 0;
    #3;
    while (!dbg_ack && c < 30) begin tick; #3; c++; end
    chk("dbg_latency", 32'(c), 32'(exp_lat));
    tick;
    dbg_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    for (int i = 0; i < LAT - 1; i++) rd_pipe[i] = BAD;
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick; tick; tick; #3;
    chk("rst_stall", {31'd0, cpu_stall}, 32'd1);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_done_ack", {30'd0, cpu_done, dbg_ack}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata | dbg_rdata, 32'd0);
    tick;
    rst = 1'b0; cpu_req = 1'b0;
    tick;

    // Single CPU store
    cpu_drive(1'b1, 32'h10, 32'hDEADBEEF);
    #3;
    chk("t1_c0_stall", {31'd0, cpu_stall}, 32'd1);
    chk("t1_c0_en", {31'd0, mem_en}, 32'd0);
    tick; #3;
    chk("t1_c1_en_we", {30'd0, mem_en, mem_we}, 32'd3);
    chk("t1_c1_addr", mem_addr, 32'h10);
    chk("t1_c1_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t1_c1_stall", {31'd0, cpu_stall}, 32'd1);
    chk("t1_c1_done", {31'd0, cpu_done}, 32'd0);
    tick; #3;
    chk("t1_c2_done", {31'd0, cpu_done}, 32'd1);
    chk("t1_c2_stall", {31'd0, cpu_stall}, 32'd0);
    chk("t1_c2_en", {31'd0, mem_en}, 32'd0);
    tick;
    cpu_req = 1'b0;

    // CPU load with 3-cycle memory latency
    cpu_drive(1'b0, 32'h10, 32'h0);
    tick; #3;
    chk("t2_c1_en_we", {30'd0, mem_en, mem_we}, 32'd2);
    tick; #3;
    chk("t2_c2_done", {31'd0, cpu_done}, 32'd0);
    chk("t2_c2_addr", mem_addr, 32'h10);
    tick; #3;
    chk("t2_c3_done", {31'd0, cpu_done}, 32'd0);
    chk("t2_c3_addr", mem_addr, 32'h10);
    tick; #3;
    chk("t2_c4_done", {31'd0, cpu_done}, 32'd1);
    chk("t2_c4_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t2_c4_addr", mem_addr, 32'h10);
    tick;
    cpu_req = 1'b0;

    // Debug write then read-back
    dbg_xfer(1'b1, 32'h20, 32'h12345678, 2);
    dbg_xfer(1'b0, 32'h20, 32'h0, LAT + 1);
    chk("t3_dbg_rdata_held", dbg_rdata, 32'h12345678);

    // Starvation: continuous CPU load against a waiting debug port, two rounds
    k = 0;
    dbg_drive(1'b1, 32'h30, 32'hA5A5A5A5);
    cpu_drive(1'b1, 32'h40, $urandom);
    for (int r = 0; r < 2; r++) begin
      cw = 0; n = 0;
      #3;
      while (!dbg_ack && n < 60) begin
        pend = cpu_done;
        tick; n++;
        if (pend) begin
          cw++; k++;
          cpu_drive(1'b1, 32'h40 + 32'(k), $urandom);
        end
        #3;
      end
      chk("starve_cpu_wins", 32'(cw), 32'd4);
      tick;
      if (r == 0) dbg_drive(1'b0, 32'h30, 32'h0);
      else dbg_req = 1'b0;
    end
    n = 0;
    #3;
    while (!cpu_done && n < 20) begin tick; #3; n++; end
    chk("starve_tail_done", {31'd0, cpu_done}, 32'd1);
    tick;
    cpu_req = 1'b0;

    // Simultaneous first requests: CPU first, DBG once the CPU lets go
    cd = -1; da = -1; n = 0;
    cpu_drive(1'b1, 32'h50, 32'h11111111);
    dbg_drive(1'b1, 32'h54, 32'h22222222);
    #3;
    while (n < 20) begin
      if (cpu_done) cd = n;
      if (dbg_ack) begin da = n; break; end
      tick; n++;
      if (cd >= 0 && n == cd + 1) cpu_req = 1'b0;
      #3;
    end
    chk("t5_cpu_done_cycle", 32'(cd), 32'd2);
    chk("t5_dbg_ack_cycle", 32'(da), 32'd5);
    tick;
    dbg_req = 1'b0; cpu_req = 1'b0;

    // Reset during WAIT of a debug read
    cpu_xfer(1'b0, 32'h50, 32'h0, LAT + 1);
    dbg_drive(1'b0, 32'h20, 32'h0);
    tick; tick;
    rst = 1'b1;
    #3;
    chk("t6_wait_no_ack", {31'd0, dbg_ack}, 32'd0);
    tick; #3;
    chk("t6_rst_ack", {31'd0, dbg_ack}, 32'd0);
    chk("t6_rst_en_we", {30'd0, mem_en, mem_we}, 32'd0);
    chk("t6_rst_addr", mem_addr, 32'd0);
    chk("t6_rst_wdata", mem_wdata, 32'd0);
    chk("t6_rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("t6_rst_cpu_rdata", cpu_rdata, 32'd0);
    rst = 1'b0; dbg_req = 1'b0;
    dbg_q.delete(); cpu_q.delete();
    tick; #3;
    chk("t6_post_no_ack", {31'd0, dbg_ack}, 32'd0);
    tick;
    dbg_xfer(1'b0, 32'h20, 32'h0, LAT + 1);
    chk("t6_reissue_rdata", dbg_rdata, 32'h12345678);

    // Random mixed traffic, one access at a time
    for (int i = 0; i < 24; i++) begin
      logic        we;
      logic [31:0] a, d;
      we = 1'($urandom_range(0, 1));
      a  = 32'h80 + 32'($urandom_range(0, 7));
      d  = $urandom;
      if ($urandom_range(0, 3) == 0) dbg_xfer(we, a, d, we ? 2 : LAT + 1);
      else cpu_xfer(we, a, d, we ? 2 : LAT + 1);
    end
    tick; tick;
    chk("sb_cpu_empty", 32'(cpu_q.size()), 32'd0);
    chk("sb_dbg_empty", 32'(dbg_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
